// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, memory
// freeze with state save/restore, IF/ID flush gating, and saturating
// stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic                   id_branch_op_i,
    input  logic                   id_flush_i,
    input  logic [4:0]             ex_rd_i,
    input  logic [4:0]             mem_rd_i,
    input  logic                   ex_regwrite_i,
    input  logic                   ex_memread_i,
    input  logic                   mem_memread_i,
    input  logic                   dmem_busy_i,
    output logic                   pc_write_o,
    output logic                   ifid_write_o,
    output logic                   idex_write_o,
    output logic                   idex_bubble_o,
    output logic                   ifid_flush_o,
    output logic                   stall_o,
    output logic [1:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HAZ     = 2'd1,
        ST_FREEZE  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    state_e                 saved_q, saved_d;
    state_e                 eff_state;
    logic [1:0]             remain_q, remain_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   ex_hit, mem_hit;
    logic [1:0]             need;
    logic                   stall_cycle;

    // A source depends on a producer only if it is really read and the
    // producer writes a non-zero register (x0 is hardwired).
    function automatic logic src_match(input logic use_src, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_src && (rs == rd) && (rd != 5'd0);
    endfunction

    // Stall cycles the ID instruction needs before its operands are ready.
    always_comb begin
        ex_hit  = src_match(id_use_rs1_i, id_rs1_i, ex_rd_i)
                | src_match(id_use_rs2_i, id_rs2_i, ex_rd_i);
        mem_hit = src_match(id_use_rs1_i, id_rs1_i, mem_rd_i)
                | src_match(id_use_rs2_i, id_rs2_i, mem_rd_i);
        need    = 2'd0;
        if (id_branch_op_i) begin
            if (ex_hit && ex_memread_i) begin
                need = 2'd2;
            end else if ((ex_hit && ex_regwrite_i) || (mem_hit && mem_memread_i)) begin
                need = 2'd1;
            end
        end else if (ex_hit && ex_memread_i) begin
            need = 2'd1;
        end
    end

    // While frozen, act as the state that was interrupted.
    assign eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;

    // Next-state and pipeline control: freeze > hazard stall > flush.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would infer a latch.
        state_d       = state_q;
        saved_d       = saved_q;
        remain_d      = remain_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        stall_o       = 1'b1;
        stall_cycle   = 1'b0;

        if (!rst) begin
            idex_bubble_o = 1'b1;
            state_d       = ST_RUN;
            saved_d       = ST_RUN;
            remain_d      = 2'd0;
        end else if (dmem_busy_i) begin
            state_d = ST_FREEZE;
            if (state_q != ST_FREEZE) begin
                saved_d = (state_q == ST_HAZ) ? ST_HAZ : ST_RUN;
            end
        end else begin
            unique case (eff_state)
                ST_RUN: begin
                    if (need != 2'd0) begin
                        stall_cycle = 1'b1;
                        if (need == 2'd2) begin
                            state_d  = ST_HAZ;
                            remain_d = 2'd1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        idex_write_o = 1'b1;
                        ifid_flush_o = id_flush_i;
                        stall_o      = 1'b0;
                        state_d      = ST_RUN;
                    end
                end
                ST_HAZ: begin
                    stall_cycle = 1'b1;
                    remain_d    = (remain_q == 2'd0) ? 2'd0 : remain_q - 2'd1;
                    state_d     = (remain_d == 2'd0) ? ST_RUN : ST_HAZ;
                end
                default: begin
                    // Unreachable encoding: hold the pipe one cycle and recover.
                    state_d  = ST_RUN;
                    saved_d  = ST_RUN;
                    remain_d = 2'd0;
                end
            endcase
            if (stall_cycle) begin
                idex_write_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cycle && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State, saved state, remaining stalls and counters; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // its next value from the same pre-edge snapshot.
        if (!rst) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            remain_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, compared against a pending-stall-count reference model. A second
// instance with 2-bit counters exercises saturation.
module tb_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, ex_rd, mem_rd;
        logic       use1, use2, branch, flush;
        logic       ex_rw, ex_mr, mem_mr, busy;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        use1, use2, branch, flush, ex_rw, ex_mr, mem_mr, busy;

    logic        pc_w_a, ifid_w_a, idex_w_a, bub_a, fl_a, st_a;
    logic [1:0]  state_a;
    logic [31:0] scnt_a;
    logic [15:0] fcnt_a;
    logic        pc_w_b, ifid_w_b, idex_w_b, bub_b, fl_b, st_b;
    logic [1:0]  state_b;
    logic [1:0]  scnt_b;
    logic [1:0]  fcnt_b;

    stim_t nxt;
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: stalls still owed, whether the last edge froze, counts.
    int    pend;
    bit    frozen;
    int    m_state;
    int    m_scnt, m_fcnt;

    always #5 clk = ~clk;

    hazard_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .id_branch_op_i(branch), .id_flush_i(flush),
        .ex_rd_i(ex_rd), .mem_rd_i(mem_rd),
        .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr), .mem_memread_i(mem_mr),
        .dmem_busy_i(busy),
        .pc_write_o(pc_w_a), .ifid_write_o(ifid_w_a), .idex_write_o(idex_w_a),
        .idex_bubble_o(bub_a), .ifid_flush_o(fl_a), .stall_o(st_a),
        .state_o(state_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    hazard_ctrl #(.STALL_CNT_W(2), .FLUSH_CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .id_branch_op_i(branch), .id_flush_i(flush),
        .ex_rd_i(ex_rd), .mem_rd_i(mem_rd),
        .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr), .mem_memread_i(mem_mr),
        .dmem_busy_i(busy),
        .pc_write_o(pc_w_b), .ifid_write_o(ifid_w_b), .idex_write_o(idex_w_b),
        .idex_bubble_o(bub_b), .ifid_flush_o(fl_b), .stall_o(st_b),
        .state_o(state_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit dep(input logic u, input logic [4:0] rs, input logic [4:0] rd);
        return u && rs == rd && rd != 0;
    endfunction

    // Stall cycles owed by the ID instruction: the largest applicable rule.
    function automatic int need_of(input stim_t s);
        bit ex_dep  = dep(s.use1, s.rs1, s.ex_rd) || dep(s.use2, s.rs2, s.ex_rd);
        bit mem_dep = dep(s.use1, s.rs1, s.mem_rd) || dep(s.use2, s.rs2, s.mem_rd);
        int n = 0;
        int cand[4];
        cand[0] = (s.branch && ex_dep && s.ex_mr) ? 2 : 0;
        cand[1] = (s.branch && ex_dep && s.ex_rw && !s.ex_mr) ? 1 : 0;
        cand[2] = (s.branch && mem_dep && s.mem_mr) ? 1 : 0;
        cand[3] = (!s.branch && ex_dep && s.ex_mr) ? 1 : 0;
        foreach (cand[i]) if (cand[i] > n) n = cand[i];
        return n;
    endfunction

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic set_idle();
        nxt = '{rst: 1'b1, rs1: 5'd0, rs2: 5'd0, ex_rd: 5'd0, mem_rd: 5'd0,
                use1: 1'b0, use2: 1'b0, branch: 1'b0, flush: 1'b0,
                ex_rw: 1'b0, ex_mr: 1'b0, mem_mr: 1'b0, busy: 1'b0};
    endtask

    // One clock: apply nxt at the falling edge, check, then advance the model.
    task automatic cycle(input bit do_check);
        logic [5:0] exp_outs;
        int n;
        bit is_stall;
        @(negedge clk);
        rst = nxt.rst; id_rs1 = nxt.rs1; id_rs2 = nxt.rs2;
        ex_rd = nxt.ex_rd; mem_rd = nxt.mem_rd; use1 = nxt.use1; use2 = nxt.use2;
        branch = nxt.branch; flush = nxt.flush; ex_rw = nxt.ex_rw;
        ex_mr = nxt.ex_mr; mem_mr = nxt.mem_mr; busy = nxt.busy;
        #1;
        n        = need_of(nxt);
        is_stall = nxt.rst && !nxt.busy && (pend > 0 || n > 0);
        if (!nxt.rst)     exp_outs = 6'b000101;
        else if (nxt.busy) exp_outs = 6'b000001;
        else if (is_stall) exp_outs = 6'b001101;
        else               exp_outs = {4'b1110, nxt.flush, 1'b0};
        if (do_check) begin
            check("outs", {pc_w_a, ifid_w_a, idex_w_a, bub_a, fl_a, st_a}, 32'(exp_outs));
            check("outs_sat", {pc_w_b, ifid_w_b, idex_w_b, bub_b, fl_b, st_b}, 32'(exp_outs));
            check("state", 32'(state_a), 32'(m_state));
            check("stall_cnt", scnt_a, 32'(m_scnt));
            check("flush_cnt", 32'(fcnt_a), 32'(sat(m_fcnt, 16'hffff)));
            check("stall_cnt_sat", 32'(scnt_b), 32'(sat(m_scnt, 3)));
            check("flush_cnt_sat", 32'(fcnt_b), 32'(sat(m_fcnt, 3)));
        end
        @(posedge clk);
        if (!nxt.rst) begin
            pend = 0; frozen = 0; m_scnt = 0; m_fcnt = 0; m_state = 0;
        end else if (nxt.busy) begin
            frozen = 1; m_state = 2;
        end else if (is_stall) begin
            m_scnt++;
            if (pend > 0) pend--;
            else pend = n - 1;
            frozen  = 0;
            m_state = (pend > 0) ? 1 : 0;
        end else begin
            if (nxt.flush) m_fcnt++;
            frozen  = 0;
            m_state = 0;
        end
    endtask

    task automatic load_use();
        set_idle();
        nxt.ex_mr = 1'b1; nxt.ex_rw = 1'b1; nxt.ex_rd = 5'd5;
        nxt.rs1 = 5'd5; nxt.use1 = 1'b1;
    endtask

    task automatic branch_after_load();
        set_idle();
        nxt.branch = 1'b1; nxt.ex_mr = 1'b1; nxt.ex_rw = 1'b1; nxt.ex_rd = 5'd7;
        nxt.rs2 = 5'd7; nxt.use2 = 1'b1;
    endtask

    initial begin
        pend = 0; frozen = 0; m_state = 0; m_scnt = 0; m_fcnt = 0;
        set_idle();
        nxt.rst = 1'b0;
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);

        // Load-use: one stall, stays in RUN.
        load_use();          cycle(1'b1);
        set_idle();          cycle(1'b1);
        check("load_use_cnt", scnt_a, 32'd1);

        // Branch after load: two stalls through HAZ.
        branch_after_load(); cycle(1'b1);
        set_idle();          cycle(1'b1);
        cycle(1'b1);
        check("branch_load_cnt", scnt_a, 32'd3);

        // Destination x0 never creates a dependency.
        set_idle(); nxt.ex_mr = 1'b1; nxt.use1 = 1'b1; cycle(1'b1);

        // Freeze during HAZ, then one remaining stall.
        branch_after_load(); cycle(1'b1);
        set_idle(); nxt.busy = 1'b1;
        repeat (3) cycle(1'b1);
        set_idle(); nxt.flush = 1'b1; cycle(1'b1);
        set_idle(); cycle(1'b1);

        // Flush in a normal cycle, ignored during a stall; saturates 2-bit copy.
        set_idle(); nxt.flush = 1'b1;
        repeat (4) cycle(1'b1);
        load_use(); nxt.flush = 1'b1; cycle(1'b1);
        set_idle(); cycle(1'b1);

        // Back-to-back load-use stalls.
        load_use(); repeat (5) cycle(1'b1);
        set_idle(); cycle(1'b1);

        // Reset in the middle of HAZ.
        branch_after_load(); cycle(1'b1);
        set_idle(); nxt.rst = 1'b0; cycle(1'b1);
        set_idle(); cycle(1'b1);
        check("reset_mid_haz_state", 32'(state_a), 32'd0);

        // Random traffic with small register numbers to make matches common.
        for (int i = 0; i < 1500; i++) begin
            nxt.rst    = ($urandom_range(0, 59) != 0);
            nxt.rs1    = 5'($urandom_range(0, 3));
            nxt.rs2    = 5'($urandom_range(0, 3));
            nxt.ex_rd  = 5'($urandom_range(0, 3));
            nxt.mem_rd = 5'($urandom_range(0, 3));
            nxt.use1   = 1'($urandom);
            nxt.use2   = 1'($urandom);
            nxt.branch = 1'($urandom);
            nxt.flush  = 1'($urandom);
            nxt.ex_rw  = 1'($urandom);
            nxt.ex_mr  = ($urandom_range(0, 2) == 0);
            nxt.mem_mr = ($urandom_range(0, 2) == 0);
            nxt.busy   = ($urandom_range(0, 5) == 0);
            cycle(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
